iot_zone_monitor: RTL and testbench

Multi-channel successor to the single active-IoT-device counter. Tracks active devices in N_CH independent zones. Each zone has an up/down counter driven by its own change/on_off strobes. Also provides a registered site-wide total, peak-occupancy tracking, per-zone threshold alarms, and sticky overflow flags, with wrap-around or saturating arithmetic chosen at elaboration.

---
 rtl/iot_zone_monitor.sv | 141 ++++++++++++++
 tb/tb_iot_zone_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_zone_monitor.sv
// -----------------------------------------------------------------------------
// iot_zone_monitor
// Tracks the number of active IoT devices in N_CH independent zones. Each zone
// keeps an up/down counter that wraps or saturates (SATURATE). The block also
// produces a registered site-wide total, the peak total since the last reset or
// clear, per-zone threshold alarms, and sticky per-zone overflow flags.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset (highest priority)
//   clr        synchronous clear of counters, total, peak, alarms, flags
//   change     per-zone event strobe (bit i = zone i updates this cycle)
//   on_off     per-zone direction (1 = device joined, 0 = device left)
//   thresh     alarm threshold shared by all zones
//   count_out  zone counters, zone i at [i*WIDTH +: WIDTH]
//   total_out  sum of zone counters, one cycle behind count_out
//   peak_out   running max of total_out, one cycle behind total_out
//   alarm      bit i = zone i count >= thresh, one cycle behind count_out
//   ovf        sticky per-zone overflow/underflow flag
// -----------------------------------------------------------------------------
module iot_zone_monitor #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0,
    localparam int TOT_W   = WIDTH + $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [N_CH-1:0]         change,
    input  logic [N_CH-1:0]         on_off,
    input  logic [WIDTH-1:0]        thresh,
    output logic [N_CH*WIDTH-1:0]   count_out,
    output logic [TOT_W-1:0]        total_out,
    output logic [TOT_W-1:0]        peak_out,
    output logic [N_CH-1:0]         alarm,
    output logic [N_CH-1:0]         ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r [N_CH];
    logic [WIDTH-1:0] count_nxt_s [N_CH];
    logic [N_CH-1:0]  ovf_hit_s;
    logic [N_CH-1:0]  ovf_r;
    logic [N_CH-1:0]  alarm_r;
    logic [N_CH-1:0]  alarm_nxt_s;
    logic [TOT_W-1:0] total_r;
    logic [TOT_W-1:0] total_sum_s;
    logic [TOT_W-1:0] peak_r;

    // Per-zone next count and overrun detection (wrap or clamp at the ends).
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            count_nxt_s[i] = count_r[i];
            ovf_hit_s[i]   = 1'b0;
            if (change[i]) begin
                if (on_off[i]) begin
                    if (count_r[i] == CNT_MAX) begin
                        ovf_hit_s[i]   = 1'b1;
                        count_nxt_s[i] = SATURATE ? CNT_MAX : CNT_ZERO;
                    end else begin
                        count_nxt_s[i] = count_r[i] + CNT_ONE;
                    end
                end else begin
                    if (count_r[i] == CNT_ZERO) begin
                        ovf_hit_s[i]   = 1'b1;
                        count_nxt_s[i] = SATURATE ? CNT_ZERO : CNT_MAX;
                    end else begin
                        count_nxt_s[i] = count_r[i] - CNT_ONE;
                    end
                end
            end else begin
                count_nxt_s[i] = count_r[i];
            end
        end
    end

    // Sum of the current (registered) zone counts and their threshold compares.
    always_comb begin
        total_sum_s = {TOT_W{1'b0}};
        alarm_nxt_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            total_sum_s    = total_sum_s + TOT_W'(count_r[i]);
            alarm_nxt_s[i] = (count_r[i] >= thresh);
        end
    end

    // Zone counters and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                count_r[i] <= CNT_ZERO;
            end
            ovf_r <= {N_CH{1'b0}};
        end else if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                count_r[i] <= CNT_ZERO;
            end
            ovf_r <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                count_r[i] <= count_nxt_s[i];
            end
            ovf_r <= ovf_r | ovf_hit_s;
        end
    end

    // Total, peak and alarm pipeline; peak compares against the previous total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_r <= {TOT_W{1'b0}};
            peak_r  <= {TOT_W{1'b0}};
            alarm_r <= {N_CH{1'b0}};
        end else if (clr) begin
            total_r <= {TOT_W{1'b0}};
            peak_r  <= {TOT_W{1'b0}};
            alarm_r <= {N_CH{1'b0}};
        end else begin
            total_r <= total_sum_s;
            peak_r  <= (total_r > peak_r) ? total_r : peak_r;
            alarm_r <= alarm_nxt_s;
        end
    end

    // Flatten the counter array onto the packed output bus.
    always_comb begin
        count_out = {(N_CH*WIDTH){1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            count_out[i*WIDTH +: WIDTH] = count_r[i];
        end
    end

    assign total_out = total_r;
    assign peak_out  = peak_r;
    assign alarm     = alarm_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_iot_zone_monitor.sv
// -----------------------------------------------------------------------------
// tb_iot_zone_monitor
// Drives a wrap-mode and a saturate-mode instance with identical stimulus. A
// reference model (plain integer arithmetic per zone) predicts the outputs
// after each edge and pushes them into per-instance queues; a monitor process
// pops one entry per clock and compares it with what the DUT shows.
// -----------------------------------------------------------------------------
module tb_iot_zone_monitor;

    typedef struct packed {
        logic [31:0] cnt;
        logic [9:0]  tot;
        logic [9:0]  pk;
        logic [3:0]  al;
        logic [3:0]  ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] change = 4'd0;
    logic [3:0] on_off = 4'd0;
    logic [7:0] thresh = 8'd10;

    logic [31:0] cnt_o [2];
    logic [9:0]  tot_o [2];
    logic [9:0]  pk_o  [2];
    logic [3:0]  al_o  [2];
    logic [3:0]  ov_o  [2];

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    int mc [2][4];
    bit mo [2][4];
    bit ma [2][4];
    int mt [2];
    int mp [2];

    always #5 clk = ~clk;

    iot_zone_monitor #(.N_CH(4), .WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .change(change), .on_off(on_off),
        .thresh(thresh), .count_out(cnt_o[0]), .total_out(tot_o[0]),
        .peak_out(pk_o[0]), .alarm(al_o[0]), .ovf(ov_o[0])
    );

    iot_zone_monitor #(.N_CH(4), .WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .change(change), .on_off(on_off),
        .thresh(thresh), .count_out(cnt_o[1]), .total_out(tot_o[1]),
        .peak_out(pk_o[1]), .alarm(al_o[1]), .ovf(ov_o[1])
    );

    task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s [%s] @%0t: got=%0d expected=%0d", nm, (m == 0) ? "wrap" : "sat", $time, got, want);
        end
    endtask

    // Advance the reference model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit c, input logic [3:0] ch, input logic [3:0] oo, input logic [7:0] th);
        for (int m = 0; m < 2; m++) begin
            if (r || c) begin
                for (int i = 0; i < 4; i++) begin
                    mc[m][i] = 0; mo[m][i] = 1'b0; ma[m][i] = 1'b0;
                end
                mt[m] = 0;
                mp[m] = 0;
            end else begin
                int nt;
                int np;
                nt = 0;
                for (int i = 0; i < 4; i++) nt += mc[m][i];
                np = (mp[m] > mt[m]) ? mp[m] : mt[m];
                for (int i = 0; i < 4; i++) begin
                    int v;
                    ma[m][i] = (mc[m][i] >= int'(th));
                    if (ch[i]) begin
                        v = mc[m][i] + (oo[i] ? 1 : -1);
                        if (v < 0 || v > 255) begin
                            mo[m][i] = 1'b1;
                            if (m == 1) v = (v < 0) ? 0 : 255;
                            else        v = (v + 256) % 256;
                        end
                        mc[m][i] = v;
                    end
                end
                mt[m] = nt;
                mp[m] = np;
            end
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, queue them.
    task automatic step(input bit r, input bit c, input logic [3:0] ch, input logic [3:0] oo, input logic [7:0] th);
        exp_t e;
        @(negedge clk);
        rst = r; clr = c; change = ch; on_off = oo; thresh = th;
        model_edge(r, c, ch, oo, th);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                e.cnt[i*8 +: 8] = mc[m][i][7:0];
                e.al[i] = ma[m][i];
                e.ov[i] = mo[m][i];
            end
            e.tot = mt[m][9:0];
            e.pk  = mp[m][9:0];
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (r) begin
            // Reset is asynchronous: outputs must already be zero before any edge.
            #1;
            for (int m = 0; m < 2; m++) begin
                chk("async_rst_cnt", m, cnt_o[m], 32'd0);
                chk("async_rst_tot", m, 32'(tot_o[m]), 32'd0);
                chk("async_rst_peak", m, 32'(pk_o[m]), 32'd0);
                chk("async_rst_alarm", m, 32'(al_o[m]), 32'd0);
                chk("async_rst_ovf", m, 32'(ov_o[m]), 32'd0);
            end
        end
    endtask

    task automatic idle(input int n, input logic [7:0] th);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 4'($urandom_range(0, 15)), th);
    endtask

    // Monitor: one expected entry per instance per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 && q0.size() > 0) || (m == 1 && q1.size() > 0)) begin
                    e = (m == 0) ? q0.pop_front() : q1.pop_front();
                    chk("count_out", m, cnt_o[m], e.cnt);
                    chk("total_out", m, 32'(tot_o[m]), 32'(e.tot));
                    chk("peak_out", m, 32'(pk_o[m]), 32'(e.pk));
                    chk("alarm", m, 32'(al_o[m]), 32'(e.al));
                    chk("ovf", m, 32'(ov_o[m]), 32'(e.ov));
                end
            end
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            mt[m] = 0; mp[m] = 0;
            for (int i = 0; i < 4; i++) begin
                mc[m][i] = 0; mo[m][i] = 1'b0; ma[m][i] = 1'b0;
            end
        end

        // Reset and hold with no change strobes.
        step(1'b1, 1'b0, 4'd0, 4'd0, 8'd10);
        step(1'b1, 1'b0, 4'd0, 4'd0, 8'd10);
        idle(10, 8'd10);

        // Independent zones: zone0 up, zone2 down (wraps), zones 1/3 idle.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b0101, 4'b0001, 8'd10);
        idle(1, 8'd10);
        @(posedge clk); #2;
        chk("indep_zone0", 0, 32'(cnt_o[0][7:0]), 32'd3);
        chk("indep_zone2", 0, 32'(cnt_o[0][23:16]), 32'd253);
        chk("indep_zone13", 0, {16'd0, cnt_o[0][31:24], cnt_o[0][15:8]}, 32'd0);
        chk("indep_ovf", 0, 32'(ov_o[0]), 32'd4);
        chk("indep_total", 0, 32'(tot_o[0]), 32'd256);
        chk("indep_sat_zone2", 1, 32'(cnt_o[1][23:16]), 32'd0);

        // Wrap up on zone1, then sticky ovf across further ups.
        step(1'b0, 1'b1, 4'd0, 4'd0, 8'd10);
        for (int k = 0; k < 256; k++) step(1'b0, 1'b0, 4'b0010, 4'b0010, 8'd10);
        @(posedge clk); #2;
        chk("wrap_zone1", 0, 32'(cnt_o[0][15:8]), 32'd0);
        chk("wrap_ovf1", 0, 32'(ov_o[0][1]), 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'b0010, 4'b0010, 8'd10);
        @(posedge clk); #2;
        chk("wrap_zone1_after", 0, 32'(cnt_o[0][15:8]), 32'd5);
        chk("wrap_ovf1_sticky", 0, 32'(ov_o[0][1]), 32'd1);

        // Saturation on zone3.
        step(1'b0, 1'b1, 4'd0, 4'd0, 8'd10);
        for (int k = 0; k < 260; k++) step(1'b0, 1'b0, 4'b1000, 4'b1000, 8'd10);
        @(posedge clk); #2;
        chk("sat_zone3_top", 1, 32'(cnt_o[1][31:24]), 32'd255);
        chk("sat_ovf3", 1, 32'(ov_o[1][3]), 32'd1);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 4'b1000, 4'b0000, 8'd10);
        @(posedge clk); #2;
        chk("sat_zone3_bottom", 1, 32'(cnt_o[1][31:24]), 32'd0);

        // Alarm and peak: zone0 to 12 then down to 4, thresh 10.
        step(1'b0, 1'b1, 4'd0, 4'd0, 8'd10);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 4'b0001, 4'b0001, 8'd10);
        for (int k = 0; k < 8; k++)  step(1'b0, 1'b0, 4'b0001, 4'b0000, 8'd10);
        idle(2, 8'd10);
        @(posedge clk); #2;
        for (int m = 0; m < 2; m++) begin
            chk("ap_peak", m, 32'(pk_o[m]), 32'd12);
            chk("ap_total", m, 32'(tot_o[m]), 32'd4);
            chk("ap_alarm0", m, 32'(al_o[m][0]), 32'd0);
        end

        // thresh = 0 raises every alarm.
        idle(2, 8'd0);

        // clr beats simultaneous up-events on every zone.
        step(1'b0, 1'b1, 4'b1111, 4'b1111, 8'd10);
        @(posedge clk); #2;
        for (int m = 0; m < 2; m++) begin
            chk("clr_cnt", m, cnt_o[m], 32'd0);
            chk("clr_peak", m, 32'(pk_o[m]), 32'd0);
        end

        // Random traffic with occasional clr and mid-sequence async reset.
        for (int k = 0; k < 600; k++) begin
            bit r;
            bit c;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 79) == 0);
            step(r, c, 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
            if (k == 300) step(1'b1, 1'b0, 4'b1111, 4'b1111, 8'd3);
        end

        idle(3, 8'd5);
        @(posedge clk); #3;
        chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
        chk("queue1_drained", 1, 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
